// File: rtl/updown_counter_ctrl_pkg.sv
// Shared encodings for the up/down counter controller: FSM states and button indices.
package updown_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

  localparam int unsigned NUM_BTNS = 3;
  localparam int unsigned BTN_RUN  = 0;
  localparam int unsigned BTN_DIR  = 1;
  localparam int unsigned BTN_CLR  = 2;

endpackage : updown_counter_ctrl_pkg

// File: rtl/updown_counter_ctrl_if.sv
// Button/tick inputs and display-path outputs of the up/down counter controller.
interface updown_counter_ctrl_if
  import updown_counter_ctrl_pkg::*;
#(
  parameter int unsigned CW = 14
) ();

  logic                tick;
  logic [NUM_BTNS-1:0] btnDb;
  logic [CW-1:0]       count;
  logic                running;
  logic                dir_down;
  logic [1:0]          state;
  logic                wrap;

  modport master (
    output tick, btnDb,
    input  count, running, dir_down, state, wrap
  );

  modport slave (
    input  tick, btnDb,
    output count, running, dir_down, state, wrap
  );

endinterface : updown_counter_ctrl_if

// File: rtl/btn_edge_detect.sv
// Rising-edge detector: one press_c pulse per low-to-high transition of each button.
module btn_edge_detect #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] press_c
);

  logic [WIDTH-1:0] btn_prev_q;
  logic [WIDTH-1:0] btn_prev_d;

  // History keeps tracking the buttons during reset too, so a button held
  // across reset must be released and pressed again to produce an event.
  always_comb begin
    btn_prev_d = btn_i;
  end

  always_ff @(posedge clk) begin
    btn_prev_q <= btn_prev_d;
  end

  assign press_c = btn_i & ~btn_prev_q;

endmodule : btn_edge_detect

// File: rtl/updown_counter_ctrl.sv
// STOP/UP/DOWN controller with tick prescaler and modulo-(MAX_COUNT+1) counter.
module updown_counter_ctrl
  import updown_counter_ctrl_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 100,
  parameter int unsigned MAX_COUNT  = 9999,
  parameter int unsigned CW         = 14
) (
  input  logic                  clk_100Mhz,
  input  logic                  rst,
  updown_counter_ctrl_if.slave  bus
);

  localparam int unsigned SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  logic [NUM_BTNS-1:0] press_c;

  state_e        state_q,    state_d;
  logic          dir_down_q, dir_down_d;
  logic          running_q,  running_d;
  logic          wrap_q,     wrap_d;
  logic [CW-1:0] count_q,    count_d;
  logic [SW-1:0] step_q,     step_d;

  btn_edge_detect #(
    .WIDTH (NUM_BTNS)
  ) u_btn_edge (
    .clk     (clk_100Mhz),
    .btn_i   (bus.btnDb),
    .press_c (press_c)
  );

  always_ff @(posedge clk_100Mhz) begin
    if (rst) begin
      state_q    <= ST_STOP;
      dir_down_q <= 1'b0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
      count_q    <= '0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      dir_down_q <= dir_down_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
      count_q    <= count_d;
      step_q     <= step_d;
    end
  end

  // Direction resolves first so a simultaneous run press starts in the new direction.
  always_comb begin
    state_d    = state_q;
    dir_down_d = dir_down_q;
    count_d    = count_q;
    step_d     = step_q;
    wrap_d     = 1'b0;

    if (press_c[BTN_DIR]) begin
      dir_down_d = ~dir_down_q;
    end

    if (press_c[BTN_RUN]) begin
      if (state_q == ST_STOP) begin
        state_d = dir_down_d ? ST_DOWN : ST_UP;
      end else begin
        state_d = ST_STOP;
      end
    end else if (press_c[BTN_DIR] && (state_q != ST_STOP)) begin
      state_d = dir_down_d ? ST_DOWN : ST_UP;
    end

    running_d = (state_d != ST_STOP);

    // Clear beats stepping; a state change restarts the prescaler.
    if (press_c[BTN_CLR]) begin
      count_d = '0;
      step_d  = '0;
    end else if (state_d != state_q) begin
      step_d = '0;
    end else if ((state_q != ST_STOP) && bus.tick) begin
      if (step_q == SW'(STEP_TICKS - 1)) begin
        step_d = '0;
        if (state_q == ST_UP) begin
          if (count_q == CW'(MAX_COUNT)) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          if (count_q == '0) begin
            count_d = CW'(MAX_COUNT);
            wrap_d  = 1'b1;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
      end else begin
        step_d = step_q + SW'(1);
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.running  = running_q;
  assign bus.dir_down = dir_down_q;
  assign bus.state    = state_q;
  assign bus.wrap     = wrap_q;

endmodule : updown_counter_ctrl
